// File: rtl/proc_pkg.sv
// Opcodes, FSM encoding and instruction field positions for param_processor_top.
// Optional multiplier: compile with PROC_MUL_EN defined to enable op D = MUL.
package proc_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_ADDI = 4'h6;
  localparam logic [3:0] OP_LDI  = 4'h7;
  localparam logic [3:0] OP_LD   = 4'h8;
  localparam logic [3:0] OP_ST   = 4'h9;
  localparam logic [3:0] OP_JMP  = 4'hA;
  localparam logic [3:0] OP_BEQZ = 4'hB;
  localparam logic [3:0] OP_DISP = 4'hC;
  localparam logic [3:0] OP_MUL  = 4'hD;
  localparam logic [3:0] OP_NOPE = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam int OP_HI = 15;
  localparam int OP_LO = 12;
  localparam int RD_HI = 11;
  localparam int RD_LO = 8;
  localparam int RS_HI = 7;
  localparam int RS_LO = 4;
  localparam int RT_HI = 3;
  localparam int RT_LO = 0;

`ifdef PROC_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    ST_LOAD, ST_FETCH, ST_EXEC, ST_MEM, ST_HALT
  } state_t;

  // Ops whose ALU result is written to rd during EXEC.
  function automatic logic writes_rd(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ADDI, OP_LDI: return 1'b1;
      OP_MUL: return MUL_EN;
      OP_NOP, OP_NOPE: return 1'b0;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/proc_alu.sv
// Combinational ALU for the parametrised processor; MUL exists only with PROC_MUL_EN.
module proc_alu
  import proc_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [7:0]        imm,
  output logic [DATA_W-1:0] result,
  output logic              zero
);

  always_comb begin
    result = '0;
    case (op)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_ADDI: result = a + DATA_W'($signed(imm[3:0]));
      OP_LDI:  result = DATA_W'(imm);
      // Branch test: the top routes rd onto a, zero flags it.
      OP_BEQZ: result = a;
`ifdef PROC_MUL_EN
      OP_MUL:  result = DATA_W'(a * b);
`endif
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/param_processor_top.sv
// Parametrised multi-cycle processor: keyed-in program, LOAD/FETCH/EXEC/MEM/HALT FSM.
// Define PROC_MUL_EN to enable the MUL opcode (otherwise op D is a NOP).
module param_processor_top
  import proc_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int NUM_REGS   = 16,
  parameter int IMEM_DEPTH = 64,
  parameter int DMEM_DEPTH = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_enable,
  input  logic [7:0]        input_instruction,
  input  logic              button,
  input  logic              run,
  output logic [DATA_W-1:0] display_output,
  output logic [15:0]       led_ins,
  output logic              halted,
  output logic              load_full
);

  localparam int IW = $clog2(IMEM_DEPTH);
  localparam int DW = $clog2(DMEM_DEPTH);
  localparam int RW = $clog2(NUM_REGS);
  localparam logic [4:0] NR = 5'(NUM_REGS);

  state_t            state_reg, state_next;
  logic [IW:0]       pc_reg, load_ptr_reg;
  logic              byte_sel_reg;
  logic [7:0]        hi_byte_reg;
  logic [15:0]       ir_reg;
  logic [DATA_W-1:0] display_reg;
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [15:0]       imem [IMEM_DEPTH];
  logic [DATA_W-1:0] dmem [DMEM_DEPTH];
  logic [DATA_W-1:0] dmem_rdata_reg;
  logic              btn_meta_reg, btn_sync_reg, btn_prev_reg, press_pend_reg;

  logic              press, imem_we, dmem_we, dmem_re, alu_zero;
  logic [3:0]        op;
  logic [RW-1:0]     rd_idx, rs_idx, rt_idx;
  logic [DATA_W-1:0] rd_val, rs_val, rt_val, alu_a, alu_result;

  assign op     = ir_reg[OP_HI:OP_LO];
  assign rd_idx = RW'({1'b0, ir_reg[RD_HI:RD_LO]} % NR);
  assign rs_idx = RW'({1'b0, ir_reg[RS_HI:RS_LO]} % NR);
  assign rt_idx = RW'({1'b0, ir_reg[RT_HI:RT_LO]} % NR);
  assign rd_val = regs[rd_idx];
  assign rs_val = regs[rs_idx];
  assign rt_val = regs[rt_idx];
  assign alu_a  = (op == OP_BEQZ) ? rd_val : rs_val;

  assign halted         = (state_reg == ST_HALT);
  assign load_full      = (load_ptr_reg == (IW+1)'(IMEM_DEPTH));
  assign display_output = display_reg;
  assign led_ins        = ir_reg;

  proc_alu #(.DATA_W(DATA_W)) u_alu (
    .op     (op),
    .a      (alu_a),
    .b      (rt_val),
    .imm    (ir_reg[7:0]),
    .result (alu_result),
    .zero   (alu_zero)
  );

  // Button sync runs every clk; a pending press survives clk_enable=0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_meta_reg   <= 1'b0;
      btn_sync_reg   <= 1'b0;
      btn_prev_reg   <= 1'b0;
      press_pend_reg <= 1'b0;
    end else begin
      btn_meta_reg   <= button;
      btn_sync_reg   <= btn_meta_reg;
      btn_prev_reg   <= btn_sync_reg;
      press_pend_reg <= (btn_sync_reg & ~btn_prev_reg) | (press_pend_reg & ~clk_enable);
    end
  end

  assign press   = press_pend_reg & clk_enable;
  assign imem_we = (state_reg == ST_LOAD) && press && !load_full && byte_sel_reg;
  assign dmem_we = clk_enable && (state_reg == ST_EXEC) && (op == OP_ST);
  assign dmem_re = clk_enable && (state_reg == ST_EXEC) && (op == OP_LD);

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_LOAD:  if (run && load_ptr_reg != '0) state_next = ST_FETCH;
      ST_FETCH: state_next = (pc_reg == load_ptr_reg) ? ST_HALT : ST_EXEC;
      ST_EXEC: begin
        if (op == OP_LD)        state_next = ST_MEM;
        else if (op == OP_HALT) state_next = ST_HALT;
        else                    state_next = ST_FETCH;
      end
      ST_MEM:   state_next = ST_FETCH;
      ST_HALT:  if (!run) state_next = ST_LOAD;
      default:  state_next = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= ST_LOAD;
      pc_reg       <= '0;
      load_ptr_reg <= '0;
      byte_sel_reg <= 1'b0;
      hi_byte_reg  <= '0;
      ir_reg       <= '0;
      display_reg  <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (clk_enable) begin
      state_reg <= state_next;
      case (state_reg)
        ST_LOAD: begin
          if (press && !load_full) begin
            byte_sel_reg <= ~byte_sel_reg;
            if (!byte_sel_reg) hi_byte_reg  <= input_instruction;
            else               load_ptr_reg <= load_ptr_reg + 1'b1;
          end
          if (state_next == ST_FETCH) pc_reg <= '0;
        end
        ST_FETCH: begin
          if (pc_reg != load_ptr_reg) begin
            ir_reg <= imem[pc_reg[IW-1:0]];
            pc_reg <= pc_reg + 1'b1;
          end
        end
        ST_EXEC: begin
          if (writes_rd(op)) regs[rd_idx] <= alu_result;
          case (op)
            OP_JMP:  pc_reg <= {1'b0, ir_reg[IW-1:0]};
            OP_BEQZ: if (alu_zero) pc_reg <= {1'b0, ir_reg[IW-1:0]};
            OP_DISP: display_reg <= rd_val;
            default: ;
          endcase
        end
        ST_MEM:  regs[rd_idx] <= dmem_rdata_reg;
        ST_HALT: if (!run) pc_reg <= '0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (imem_we) imem[load_ptr_reg[IW-1:0]] <= {hi_byte_reg, input_instruction};
  end

  // DMEM read is issued in EXEC so the data is ready for the MEM cycle.
  always_ff @(posedge clk) begin
    if (dmem_we) dmem[rs_val[DW-1:0]] <= rd_val;
    if (dmem_re) dmem_rdata_reg <= dmem[rs_val[DW-1:0]];
  end

endmodule

// File: tb/tb_param_processor_top.sv
// Self-checking bench for param_processor_top: table of keyed programs plus
// hand-written load-full, clock-enable freeze and reset-in-EXEC sequences.
module tb_param_processor_top;

  localparam int DATA_W     = 8;
  localparam int NUM_REGS   = 16;
  localparam int IMEM_DEPTH = 16;
  localparam int DMEM_DEPTH = 16;

`ifdef PROC_MUL_EN
  localparam logic [7:0] MUL_EXP = 8'h2A;
`else
  localparam logic [7:0] MUL_EXP = 8'h00;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              clk_enable = 1'b1;
  logic [7:0]        input_instruction = 8'h00;
  logic              button = 1'b0;
  logic              run = 1'b0;
  logic [DATA_W-1:0] display_output;
  logic [15:0]       led_ins;
  logic              halted;
  logic              load_full;

  param_processor_top #(
    .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .IMEM_DEPTH(IMEM_DEPTH), .DMEM_DEPTH(DMEM_DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable),
    .input_instruction(input_instruction), .button(button), .run(run),
    .display_output(display_output), .led_ins(led_ins),
    .halted(halted), .load_full(load_full)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0][15:0] prog;
    int               len;
    int               n_exec;
    int               n_ld;
    logic [7:0]       disp;
  } vec_t;

  typedef struct packed {
    int         id;
    logic [7:0] disp;
    logic [15:0] ir;
    int         cycles;
  } exp_t;

  vec_t vecs [12];
  exp_t sb [$];
  int   n_checks = 0;
  int   n_fail = 0;

  function automatic vec_t mk(input logic [15:0] w0, w1, w2, w3, w4, w5,
                              input int len, input int n_exec, input int n_ld,
                              input logic [7:0] disp);
    vec_t v;
    v.prog   = {w5, w4, w3, w2, w1, w0};
    v.len    = len;
    v.n_exec = n_exec;
    v.n_ld   = n_ld;
    v.disp   = disp;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; run = 1'b0; button = 1'b0; clk_enable = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic key_byte(input logic [7:0] b);
    input_instruction = b;
    button = 1'b1;
    repeat (4) @(negedge clk);
    button = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic key_word(input logic [15:0] w);
    key_byte(w[15:8]);
    key_byte(w[7:0]);
  endtask

  // Raise run, count clocks until HALT, then score against the queued expectation.
  task automatic run_prog(input string tag);
    exp_t e;
    int   cyc;
    bit   done;
    cyc = 0;
    done = 1'b0;
    run = 1'b1;
    while (!done && cyc < 200) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (halted) done = 1'b1;
    end
    e = sb.pop_front();
    check({tag, " halted"}, 32'(done), 32'd1);
    check({tag, " display"}, 32'(display_output), 32'(e.disp));
    check({tag, " led_ins"}, 32'(led_ins), 32'(e.ir));
    check({tag, " cycles"}, cyc, e.cycles);
    run = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check({tag, " back to LOAD"}, 32'(halted), 32'd0);
  endtask

  initial begin
    exp_t e;
    vecs[0]  = mk(16'h7105, 16'h7203, 16'h1312, 16'hC300, 16'hF000, 16'h0000, 5, 5, 0, 8'h08);
    vecs[1]  = mk(16'h71F0, 16'h7220, 16'h1312, 16'hC300, 16'hF000, 16'h0000, 5, 5, 0, 8'h10);
    vecs[2]  = mk(16'h7103, 16'h7205, 16'h2312, 16'hC300, 16'hF000, 16'h0000, 5, 5, 0, 8'hFE);
    vecs[3]  = mk(16'h71CC, 16'h72AA, 16'h3312, 16'hC300, 16'hF000, 16'h0000, 5, 5, 0, 8'h88);
    vecs[4]  = mk(16'h71C0, 16'h720A, 16'h4312, 16'hC300, 16'hF000, 16'h0000, 5, 5, 0, 8'hCA);
    vecs[5]  = mk(16'h71FF, 16'h720F, 16'h5312, 16'hC300, 16'hF000, 16'h0000, 5, 5, 0, 8'hF0);
    vecs[6]  = mk(16'h7110, 16'h631F, 16'hC300, 16'hF000, 16'h0000, 16'h0000, 4, 4, 0, 8'h0F);
    vecs[7]  = mk(16'h71AA, 16'h9100, 16'h8200, 16'hC200, 16'hF000, 16'h0000, 5, 5, 1, 8'hAA);
    vecs[8]  = mk(16'h71FF, 16'h6111, 16'hB104, 16'h7177, 16'hC100, 16'hF000, 6, 5, 0, 8'h00);
    vecs[9]  = mk(16'h7101, 16'hA003, 16'h7109, 16'hC100, 16'hF000, 16'h0000, 5, 4, 0, 8'h01);
    vecs[10] = mk(16'h7107, 16'h7206, 16'hD312, 16'hC300, 16'hF000, 16'h0000, 5, 5, 0, MUL_EXP);
    vecs[11] = mk(16'h7103, 16'hB104, 16'h7177, 16'hC100, 16'hF000, 16'h0000, 5, 5, 0, 8'h77);

    // Reset state
    repeat (2) @(negedge clk);
    check("reset display", 32'(display_output), 32'd0);
    check("reset led_ins", 32'(led_ins), 32'd0);
    check("reset halted", 32'(halted), 32'd0);
    check("reset load_full", 32'(load_full), 32'd0);
    reset = 1'b1;

    for (int i = 0; i < 12; i++) begin
      do_reset();
      for (int w = 0; w < vecs[i].len; w++) key_word(vecs[i].prog[w]);
      e.id     = i;
      e.disp   = vecs[i].disp;
      e.ir     = 16'hF000;
      e.cycles = 2 * vecs[i].n_exec + vecs[i].n_ld + 1;
      sb.push_back(e);
      run_prog($sformatf("vec%0d", i));
    end

    // Fill IMEM completely; extra presses must be ignored.
    do_reset();
    for (int i = 0; i < 15; i++) key_word(16'h7100 | 16'(i));
    key_word(16'hC100);
    check("full after fill", 32'(load_full), 32'd1);
    key_word(16'hF000);
    check("full after extra press", 32'(load_full), 32'd1);
    e.id = 100; e.disp = 8'h0E; e.ir = 16'hC100; e.cycles = 34;
    sb.push_back(e);
    run_prog("full");

    // Freeze mid-run with clk_enable=0, then reset while in EXEC.
    do_reset();
    key_word(16'h7105); key_word(16'h7203); key_word(16'h1312);
    key_word(16'hC300); key_word(16'hF000);
    run = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("pre-freeze led_ins", 32'(led_ins), 32'hC300);
    clk_enable = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("frozen led_ins", 32'(led_ins), 32'hC300);
    check("frozen display", 32'(display_output), 32'h00);
    check("frozen halted", 32'(halted), 32'd0);
    clk_enable = 1'b1;
    @(posedge clk); @(negedge clk);
    check("resume display", 32'(display_output), 32'h08);
    @(posedge clk); @(negedge clk);
    check("exec led_ins", 32'(led_ins), 32'hF000);
    reset = 1'b0;
    #1;
    check("async rst led_ins", 32'(led_ins), 32'd0);
    check("async rst display", 32'(display_output), 32'd0);
    check("async rst halted", 32'(halted), 32'd0);
    run = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
